sevenseg_scan: RTL

//  Time-multiplexed driver for an N-digit common-anode seven-segment display.

---
 rtl/sevenseg_pkg.sv | 37 +++
 rtl/sevenseg_scan_divider.sv | 34 +++
 rtl/sevenseg_scan.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: shared types, blank pattern and hex glyph encoder for the
// seven-segment scan driver.
`default_nettype none

package sevenseg_pkg;

   typedef logic [3:0] nibble_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-low glyphs, bit order {g,f,e,d,c,b,a}
   function automatic logic [6:0] seg_encode(input nibble_t nib);
      logic [6:0] seg;
      case (nib)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         default: seg = 7'h0E;
      endcase
      return seg;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sevenseg_scan_divider.sv
// scan_divider: free-running slot counter 0..REFRESH_DIV-1 with a wrap strobe
// on the last cycle of each slot.
`default_nettype none

module scan_divider #(
   parameter int REFRESH_DIV = 50000,
   parameter int SLOT_W      = $clog2(REFRESH_DIV)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   output logic [SLOT_W-1:0] slot_o,
   output logic              wrap_o
);

   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(REFRESH_DIV - 1);

   logic [SLOT_W-1:0] slot_q;
   logic [SLOT_W-1:0] slot_d;

   assign wrap_o = (slot_q == LAST_SLOT);
   assign slot_o = slot_q;

   always_comb begin
      slot_d = wrap_o ? '0 : slot_q + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) slot_q <= '0;
      else         slot_q <= slot_d;
   end

endmodule

`default_nettype wire

// File: rtl/sevenseg_scan.sv
// sevenseg_scan: time-multiplexed common-anode seven-segment driver with
// frame-synchronous update, leading-zero blanking, decimal points and guard.
`default_nettype none

module sevenseg_scan
   import sevenseg_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int GUARD       = 8
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [4*NUM_DIGITS-1:0] value_i,
   input  logic [NUM_DIGITS-1:0]   dp_in_i,
   input  logic                    load_i,
   input  logic                    lz_blank_i,
   output logic [6:0]              segments_o,
   output logic                    dp_o,
   output logic [NUM_DIGITS-1:0]   anodes_o,
   output logic                    frame_tick_o,
   output logic                    pending_o
);

   localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int SLOT_W = $clog2(REFRESH_DIV);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

   logic [SLOT_W-1:0]       slot;
   logic                    slot_wrap;
   logic                    frame_wrap;

   logic [IDX_W-1:0]        idx_q,       idx_d;
   logic [4*NUM_DIGITS-1:0] pend_val_q,  pend_val_d;
   logic [NUM_DIGITS-1:0]   pend_dp_q,   pend_dp_d;
   logic                    pending_q,   pending_d;
   logic [4*NUM_DIGITS-1:0] disp_val_q,  disp_val_d;
   logic [NUM_DIGITS-1:0]   disp_dp_q,   disp_dp_d;
   logic [6:0]              seg_q,       seg_d;
   logic                    dp_q,        dp_d;
   logic [NUM_DIGITS-1:0]   an_q,        an_d;
   logic                    tick_q,      tick_d;

   logic [NUM_DIGITS-1:0]   blank_vec;
   logic                    zero_run;
   nibble_t                 nib_sel;
   logic                    dp_sel;
   logic                    blank_sel;
   logic                    in_guard;

   scan_divider #(
      .REFRESH_DIV (REFRESH_DIV),
      .SLOT_W      (SLOT_W)
   ) u_div (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .slot_o (slot),
      .wrap_o (slot_wrap)
   );

   assign frame_wrap = slot_wrap && (idx_q == LAST_IDX);

   always_comb begin
      idx_d      = idx_q;
      pend_val_d = pend_val_q;
      pend_dp_d  = pend_dp_q;
      pending_d  = pending_q;
      disp_val_d = disp_val_q;
      disp_dp_d  = disp_dp_q;
      if (slot_wrap) idx_d = frame_wrap ? '0 : idx_q + 1'b1;
      // Promotion uses the old pending data; a same-cycle load stays pending
      if (frame_wrap && pending_q) begin
         disp_val_d = pend_val_q;
         disp_dp_d  = pend_dp_q;
         pending_d  = 1'b0;
      end
      if (load_i) begin
         pend_val_d = value_i;
         pend_dp_d  = dp_in_i;
         pending_d  = 1'b1;
      end
      tick_d = frame_wrap;
   end

   // A digit blanks when it and every more-significant nibble are zero
   always_comb begin
      zero_run  = 1'b1;
      blank_vec = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         zero_run     = zero_run && (disp_val_q[4*k +: 4] == 4'h0);
         blank_vec[k] = zero_run && lz_blank_i && (k != 0);
      end
   end

   always_comb begin
      nib_sel   = '0;
      dp_sel    = 1'b0;
      blank_sel = 1'b0;
      in_guard  = (32'(slot) < GUARD);
      an_d      = '1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx_q == IDX_W'(k)) begin
            nib_sel   = disp_val_q[4*k +: 4];
            dp_sel    = disp_dp_q[k];
            blank_sel = blank_vec[k];
            an_d[k]   = in_guard;
         end
      end
      seg_d = (in_guard || blank_sel) ? SEG_BLANK : seg_encode(nib_sel);
      dp_d  = in_guard ? 1'b1 : ~dp_sel;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         idx_q      <= '0;
         pend_val_q <= '0;
         pend_dp_q  <= '0;
         pending_q  <= 1'b0;
         disp_val_q <= '0;
         disp_dp_q  <= '0;
         seg_q      <= SEG_BLANK;
         dp_q       <= 1'b1;
         an_q       <= '1;
         tick_q     <= 1'b0;
      end else begin
         idx_q      <= idx_d;
         pend_val_q <= pend_val_d;
         pend_dp_q  <= pend_dp_d;
         pending_q  <= pending_d;
         disp_val_q <= disp_val_d;
         disp_dp_q  <= disp_dp_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
         an_q       <= an_d;
         tick_q     <= tick_d;
      end
   end

   assign segments_o   = seg_q;
   assign dp_o         = dp_q;
   assign anodes_o     = an_q;
   assign frame_tick_o = tick_q;
   assign pending_o    = pending_q;

endmodule

`default_nettype wire
